// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo duty ramp block.
// Holds the FSM state enum, default timing/scaling constants and the duty word width,
// plus the angle-to-duty conversion used for both reset and commanded targets.
package servo_pkg;

    localparam int DUTY_W       = 20;
    localparam int FRAME_TICKS  = 1_000_000;
    localparam int DUTY_MIN     = 25_000;
    localparam int DUTY_PER_DEG = 556;
    localparam int ANGLE_MAX    = 180;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RAMP = 2'd2
    } state_t;

    // Duty word for an already-clamped angle; evaluated at duty width.
    function automatic logic [DUTY_W-1:0] angle_to_duty(
        input logic [7:0]        angle,
        input logic [DUTY_W-1:0] base,
        input logic [DUTY_W-1:0] per_deg
    );
        return base + DUTY_W'(angle) * per_deg;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running frame counter: counts 0..FRAME_TICKS-1 on negedge clk and wraps.
// Ports: clk, rst_n (sync, active-low), frame_tick (high while count is at its last value).
// Never restarted except by reset; frame_tick is a decode of the registered count.
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int FRAME_TICKS = servo_pkg::FRAME_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    output logic frame_tick
);

    localparam int CNT_W = (FRAME_TICKS > 2) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_TICKS - 1);

    logic [CNT_W-1:0] count;

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign frame_tick = (count == LAST);

endmodule

// File: rtl/servo_duty_ramp.sv
// Converts a commanded servo angle into a 20-bit PWM duty word and slews it once per frame.
// Ports: clk, rst_n (sync, active-low), angle_in/angle_valid/angle_ready handshake,
// duty (registered), busy, frame_tick. All state updates on negedge clk.
// Build option: SERVO_RAMP_EN selects bounded-step slewing; without it duty jumps to target.
module servo_duty_ramp
    import servo_pkg::*;
#(
    parameter int FRAME_TICKS  = servo_pkg::FRAME_TICKS,
    parameter int DUTY_MIN     = servo_pkg::DUTY_MIN,
    parameter int DUTY_PER_DEG = servo_pkg::DUTY_PER_DEG,
    parameter int ANGLE_MAX    = servo_pkg::ANGLE_MAX,
`ifdef SERVO_RAMP_EN
    parameter int RAMP_STEP    = 5_560,
`endif
    parameter int INIT_ANGLE   = 90
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        angle_in,
    input  logic              angle_valid,
    output logic              angle_ready,
    output logic [DUTY_W-1:0] duty,
    output logic              busy,
    output logic              frame_tick
);

    localparam logic [7:0]        ANGLE_MAX_W = 8'(ANGLE_MAX);
    localparam logic [7:0]        INIT_ANG_W  = 8'(INIT_ANGLE);
    localparam logic [DUTY_W-1:0] MIN_W       = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0] PER_DEG_W   = DUTY_W'(DUTY_PER_DEG);
    localparam logic [DUTY_W-1:0] INIT_DUTY   = angle_to_duty(INIT_ANG_W, MIN_W, PER_DEG_W);

    state_t            state, state_nxt;
    logic [DUTY_W-1:0] duty_nxt;
    logic [DUTY_W-1:0] target, target_nxt;
    logic [7:0]        angle_q, angle_nxt;
    logic [DUTY_W-1:0] load_target;
    logic [DUTY_W-1:0] stepped;
    logic              accept;

    servo_frame_timer #(
        .FRAME_TICKS(FRAME_TICKS)
    ) u_frame_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick)
    );

    // The clamped angle is captured at accept; the multiply happens in LOAD.
    assign load_target = angle_to_duty(angle_q, MIN_W, PER_DEG_W);

`ifdef SERVO_RAMP_EN
    localparam logic [DUTY_W-1:0] STEP_W = DUTY_W'(RAMP_STEP);
    logic              going_up;
    logic [DUTY_W-1:0] dist;

    // Landing exactly on target when within one step keeps duty from overshooting.
    assign going_up = (target > duty);
    assign dist     = going_up ? (target - duty) : (duty - target);
    assign stepped  = (dist <= STEP_W) ? target
                    : (going_up ? (duty + STEP_W) : (duty - STEP_W));
`else
    assign stepped  = target;
`endif

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            duty    <= INIT_DUTY;
            target  <= INIT_DUTY;
            angle_q <= INIT_ANG_W;
        end else begin
            state   <= state_nxt;
            duty    <= duty_nxt;
            target  <= target_nxt;
            angle_q <= angle_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        duty_nxt    = duty;
        target_nxt  = target;
        angle_nxt   = angle_q;
        angle_ready = (state != LOAD);
        busy        = (state != IDLE);
        accept      = angle_valid && (state != LOAD);

        if (accept) begin
            angle_nxt = (angle_in > ANGLE_MAX_W) ? ANGLE_MAX_W : angle_in;
        end

        case (state)
            IDLE: begin
                if (accept) state_nxt = LOAD;
            end
            LOAD: begin
                // A frame_tick here is deliberately ignored: no step while loading.
                target_nxt = load_target;
                state_nxt  = (load_target == duty) ? IDLE : RAMP;
            end
            RAMP: begin
                // Step toward the current target first; a coincident accept
                // then redirects to LOAD using the already-stepped duty.
                if (frame_tick) begin
                    duty_nxt = stepped;
                    if (stepped == target) state_nxt = IDLE;
                end
                if (accept) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_servo_duty_ramp.sv
// Self-checking bench for servo_duty_ramp with a short frame (20 clocks).
// Expected duty words are queued when a command is driven and popped after each frame_tick.
// DUT acts on negedge; the bench samples and drives just after posedge.
module tb_servo_duty_ramp;

    localparam int FT       = 20;
    localparam int D_MIN    = 25_000;
    localparam int D_PER    = 556;
    localparam int A_MAX    = 180;
    localparam int STEP     = 5_560;
    localparam int D_INIT   = 75_040;

    logic        clk;
    logic        rst_n;
    logic [7:0]  angle_in;
    logic        angle_valid;
    logic        angle_ready;
    logic [19:0] duty;
    logic        busy;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    logic [19:0] m_duty;
    logic [19:0] m_target;
    logic [19:0] exp_q[$];

    servo_duty_ramp #(.FRAME_TICKS(FT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .angle_in   (angle_in),
        .angle_valid(angle_valid),
        .angle_ready(angle_ready),
        .duty       (duty),
        .busy       (busy),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] calc_target(input int a);
        int c;
        c = (a > A_MAX) ? A_MAX : a;
        return 20'(D_MIN + c * D_PER);
    endfunction

    function automatic logic [19:0] model_step(input logic [19:0] d, input logic [19:0] t);
`ifdef SERVO_RAMP_EN
        if (t > d) return ((t - d) <= 20'(STEP)) ? t : d + 20'(STEP);
        else       return ((d - t) <= 20'(STEP)) ? t : d - 20'(STEP);
`else
        return t;
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        m_duty   = 20'(D_INIT);
        m_target = 20'(D_INIT);
        exp_q.delete();
    endtask

    // Checks frame_tick phase: sample 0 is the first one after the reset edge.
    task automatic check_tick_phase(input int samples);
        for (int i = 0; i < samples; i++) begin
            checks++;
            if (frame_tick !== ((i % FT) == FT - 1)) begin
                errors++;
                $display("FAIL tick_phase[%0d]: got %b expected %b", i, frame_tick, (i % FT) == FT - 1);
            end
            checks++;
            if (duty !== m_duty) begin
                errors++;
                $display("FAIL idle_duty[%0d]: got %0d expected %0d", i, duty, m_duty);
            end
            cycle();
        end
    endtask

    // Drives one command; if it meets a frame_tick while ramping, the model steps first.
    task automatic send(input int a);
        logic [19:0] d;
        checks++;
        if (angle_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_send: got %b expected 1", angle_ready);
        end
        angle_in    = 8'(a);
        angle_valid = 1'b1;
        if (frame_tick === 1'b1 && exp_q.size() > 0) m_duty = model_step(m_duty, m_target);
        cycle();
        angle_valid = 1'b0;
        checks++;
        if (angle_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_load: got %b expected 0", angle_ready);
        end
        checks++;
        if (duty !== m_duty) begin
            errors++;
            $display("FAIL duty_at_load: got %0d expected %0d", duty, m_duty);
        end
        m_target = calc_target(a);
        exp_q.delete();
        d = m_duty;
        while (d != m_target) begin
            d = model_step(d, m_target);
            exp_q.push_back(d);
        end
        if (exp_q.size() == 0) begin
            cycle();
            checks++;
            if (busy !== 1'b0 || angle_ready !== 1'b1 || duty !== m_duty) begin
                errors++;
                $display("FAIL load_to_idle: got busy=%b ready=%b duty=%0d expected busy=0 ready=1 duty=%0d",
                         busy, angle_ready, duty, m_duty);
            end
        end
    endtask

    // Pops expected duties after each observed frame_tick; duty must hold otherwise.
    task automatic drain(input int max_pops);
        int  pops = 0;
        int  n = 0;
        bit  prev_tick = 1'b0;
        int  budget;
        logic [19:0] e;
        budget = (exp_q.size() + 1) * (FT + 5);
        while (exp_q.size() > 0 && (max_pops < 0 || pops < max_pops) && n < budget) begin
            cycle();
            n++;
            if (prev_tick) begin
                e = exp_q.pop_front();
                pops++;
                m_duty = e;
                checks++;
                if (duty !== e) begin
                    errors++;
                    $display("FAIL duty_step: got %0d expected %0d", duty, e);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_after_ramp: got %b expected 0", busy);
                    end
                end
            end else begin
                checks++;
                if (duty !== m_duty) begin
                    errors++;
                    $display("FAIL duty_hold: got %0d expected %0d", duty, m_duty);
                end
            end
            prev_tick = frame_tick;
        end
        if (exp_q.size() > 0 && (max_pops < 0 || pops < max_pops)) begin
            errors++;
            $display("FAIL drain_timeout: got %0d steps expected %0d more", pops, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        while (frame_tick !== 1'b1 && n < 2 * FT) begin
            cycle();
            n++;
        end
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL wait_tick_timeout: got no frame_tick expected one within %0d cycles", 2 * FT);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (duty !== 20'd75040 || busy !== 1'b0 || angle_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got duty=%0d busy=%b ready=%b expected duty=75040 busy=0 ready=1",
                     duty, busy, angle_ready);
        end
        check_tick_phase(3 * FT);
    endtask

    task automatic test_same_angle();
        apply_reset();
        send(90);
    endtask

    task automatic test_small_step();
        apply_reset();
        send(91);
        drain(-1);
        checks++;
        if (duty !== 20'd75596) begin
            errors++;
            $display("FAIL one_degree: got %0d expected 75596", duty);
        end
    endtask

    task automatic test_ramp_down();
        apply_reset();
        send(0);
        drain(-1);
        checks++;
        if (duty !== 20'd25000) begin
            errors++;
            $display("FAIL ramp_down_final: got %0d expected 25000", duty);
        end
    endtask

    task automatic test_clamp();
        apply_reset();
        send(200);
        drain(-1);
        checks++;
        if (duty !== 20'd125080) begin
            errors++;
            $display("FAIL clamp_final: got %0d expected 125080", duty);
        end
    endtask

    task automatic test_retarget();
        apply_reset();
        send(0);
        drain(3);
`ifdef SERVO_RAMP_EN
        checks++;
        if (duty !== 20'd58360) begin
            errors++;
            $display("FAIL retarget_mid: got %0d expected 58360", duty);
        end
`endif
        send(180);
        drain(-1);
    endtask

    task automatic test_coincident();
        apply_reset();
        send(0);
        wait_tick();
        send(180);
        drain(-1);
    endtask

    task automatic test_reset_mid_ramp();
        apply_reset();
        send(0);
        drain(2);
        apply_reset();
        checks++;
        if (duty !== 20'd75040 || busy !== 1'b0 || angle_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ramp: got duty=%0d busy=%b ready=%b expected duty=75040 busy=0 ready=1",
                     duty, busy, angle_ready);
        end
        check_tick_phase(FT + 2);
    endtask

    initial begin
        rst_n       = 1'b0;
        angle_in    = 8'd0;
        angle_valid = 1'b0;
        m_duty      = 20'(D_INIT);
        m_target    = 20'(D_INIT);
        cycle();
        cycle();
        test_reset();
        test_same_angle();
        test_small_step();
        test_ramp_down();
        test_clamp();
        test_retarget();
        test_coincident();
        test_reset_mid_ramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
